// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared state type and constants for the UART transmit arbiter.
package uart_tx_arbiter_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} uart_tx_arb_state_t;
   localparam int UART_TX_ARB_MAX_REQ       = 8;
   localparam int UART_TX_ARB_START_TIMEOUT = 4096;
endpackage

// File: rtl/uart_tx_arb_picker.sv
// uart_tx_arb_picker: combinational winner selection, round-robin from ptr by default,
// lowest-index fixed priority when UART_TX_ARBITER_FIXED_PRIORITY_EN is defined.
module uart_tx_arb_picker #(
   parameter int N_REQ = 2
)(
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [$clog2(N_REQ)-1:0] ptr,
   output logic [$clog2(N_REQ)-1:0] winner,
   output logic                     any_valid
);
   localparam int IW = $clog2(N_REQ);
   localparam int SW = IW + 1;

   assign any_valid = |req_valid;

`ifdef UART_TX_ARBITER_FIXED_PRIORITY_EN
   always_comb begin
      winner = '0;
      for (int i = N_REQ - 1; i >= 0; i--)
         if (req_valid[i]) winner = IW'(i);
   end
`else
   logic [SW-1:0] sum;
   logic [IW-1:0] idx;

   // Offsets are walked downward so the candidate nearest the pointer is written last.
   always_comb begin
      winner = '0;
      sum    = '0;
      idx    = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         sum = {1'b0, ptr} + SW'(i);
         idx = (sum >= SW'(N_REQ)) ? IW'(sum - SW'(N_REQ)) : IW'(sum);
         if (req_valid[idx]) winner = idx;
      end
   end
`endif
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among N_REQ byte producers, one byte per grant.
// Define UART_TX_ARBITER_FIXED_PRIORITY_EN for lowest-index priority instead of round-robin.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int N_REQ         = 2,
   parameter int START_TIMEOUT = UART_TX_ARB_START_TIMEOUT
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ-1:0][7:0]    req_data,
   output logic [N_REQ-1:0]         req_ready,
   output logic [7:0]               tx_data,
   output logic                     tx_data_valid,
   input  logic                     tx_busy,
   output logic [$clog2(N_REQ)-1:0] grant_id,
   output logic                     active,
   output logic                     timeout_err
);
   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2(START_TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(START_TIMEOUT - 1);

   if (N_REQ < 2 || N_REQ > UART_TX_ARB_MAX_REQ) begin : g_bad_n_req
      $error("uart_tx_arbiter: N_REQ out of range");
   end

   uart_tx_arb_state_t state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d, id_q, id_d, winner, id_next;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    data_q, data_d;
   logic          any_valid;

   uart_tx_arb_picker #(.N_REQ(N_REQ)) u_picker (
      .req_valid (req_valid),
      .ptr       (ptr_q),
      .winner    (winner),
      .any_valid (any_valid)
   );

   assign id_next       = (id_q == IW'(N_REQ - 1)) ? '0 : id_q + IW'(1);
   assign tx_data       = data_q;
   assign grant_id      = id_q;
   assign active        = state_q != IDLE;

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      cnt_d         = cnt_q;
      data_d        = data_q;
      id_d          = id_q;
      req_ready     = '0;
      tx_data_valid = 1'b0;
      timeout_err   = 1'b0;
      case (state_q)
         // rst_n gates the grant so req_ready stays low while reset is held.
         IDLE: if (rst_n && en && any_valid && !tx_busy) begin
            req_ready[winner] = 1'b1;
            data_d            = req_data[winner];
            id_d              = winner;
            state_d           = ISSUE;
         end
         ISSUE: begin
            tx_data_valid = 1'b1;
            cnt_d         = '0;
            state_d       = WAIT_START;
         end
         WAIT_START: if (tx_busy) begin
            state_d = WAIT_DONE;
         end else if (cnt_q == CNT_LAST) begin
            timeout_err = 1'b1;
            ptr_d       = id_next;
            state_d     = IDLE;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
         WAIT_DONE: if (!tx_busy) begin
            ptr_d   = id_next;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         id_q    <= id_d;
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter (N_REQ=2, START_TIMEOUT=16),
// expectations follow UART_TX_ARBITER_FIXED_PRIORITY_EN when it is defined.
module tb_uart_tx_arbiter;
   localparam int N  = 2;
   localparam int TO = 16;
`ifdef UART_TX_ARBITER_FIXED_PRIORITY_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              en = 1'b0;
   logic [N-1:0]      req_valid = '0;
   logic [N-1:0][7:0] req_data = '0;
   logic [N-1:0]      req_ready;
   logic [7:0]        tx_data;
   logic              tx_data_valid;
   logic              tx_busy;
   logic [0:0]        grant_id;
   logic              active;
   logic              timeout_err;
   logic              model_on = 1'b0;
   logic              busy_force = 1'b0;
   int                bcnt = 0;
   int                total = 0;
   int                bad = 0;
   int                n_rdy;
   int                n_to;

   uart_tx_arbiter #(.N_REQ(N), .START_TIMEOUT(TO)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .en            (en),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .tx_data       (tx_data),
      .tx_data_valid (tx_data_valid),
      .tx_busy       (tx_busy),
      .grant_id      (grant_id),
      .active        (active),
      .timeout_err   (timeout_err)
   );

   always #5 clk = ~clk;

   // Transmitter stand-in: busy for 10 cycles after each start pulse.
   always @(posedge clk)
      if (model_on && tx_data_valid) bcnt <= 10;
      else if (bcnt > 0) bcnt <= bcnt - 1;

   assign tx_busy = model_on ? (bcnt > 0) : busy_force;

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for a grant, then checks ready, the start pulse one cycle later and its end.
   task automatic grant_once(input logic [1:0] er, input logic [7:0] ed, input int budget, input int exp_wait);
      int n = 0;
      while (req_ready == '0 && n < budget) begin
         tick();
         n++;
      end
      chk("ready", 32'(req_ready), 32'(er));
      if (exp_wait >= 0) chk("gap", n, exp_wait);
      tick();
      chk("ready_one_cycle", 32'(req_ready), 0);
      chk("valid", 32'(tx_data_valid), 1);
      chk("data", 32'(tx_data), 32'(ed));
      chk("gid", 32'(grant_id), 32'(er[1]));
      tick();
      chk("valid_one_cycle", 32'(tx_data_valid), 0);
   endtask

   initial begin
      en          = 1'b1;
      req_valid   = 2'b11;
      req_data[0] = 8'hA5;
      req_data[1] = 8'h5A;
      model_on    = 1'b1;
      tick();
      tick();
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_data", 32'(tx_data), 0);
      chk("rst_valid", 32'(tx_data_valid), 0);
      chk("rst_gid", 32'(grant_id), 0);
      chk("rst_active", 32'(active), 0);
      chk("rst_timeout", 32'(timeout_err), 0);
      rst_n = 1'b1;
      #1;
      grant_once(2'b01, 8'hA5, 2, -1);
      tick();
      chk("mid_active", 32'(active), 1);
      chk("mid_busy", 32'(tx_busy), 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_active", 32'(active), 0);
      chk("midrst_valid", 32'(tx_data_valid), 0);
      chk("midrst_ready", 32'(req_ready), 0);
      req_data[0] = 8'h11;
      req_data[1] = 8'h22;
      tick();
      rst_n = 1'b1;
      #1;
      grant_once(2'b01, 8'h11, 20, -1);
      grant_once(FIXED ? 2'b01 : 2'b10, FIXED ? 8'h11 : 8'h22, 30, 11);
      grant_once(2'b01, 8'h11, 30, 11);
      grant_once(FIXED ? 2'b01 : 2'b10, FIXED ? 8'h11 : 8'h22, 30, 11);
      model_on = 1'b0;
      repeat (TO - 2) tick();
      chk("to_early", 32'(timeout_err), 0);
      chk("to_active", 32'(active), 1);
      tick();
      chk("to_pulse", 32'(timeout_err), 1);
      chk("to_noready", 32'(req_ready), 0);
      tick();
      chk("to_one_cycle", 32'(timeout_err), 0);
      grant_once(2'b01, 8'h11, 0, 0);
      en    = 1'b0;
      n_rdy = 0;
      n_to  = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (req_ready != '0) n_rdy++;
         if (timeout_err) n_to++;
      end
      chk("en_gate_ready", n_rdy, 0);
      chk("en_gate_timeout", n_to, 1);
      chk("en_gate_idle", 32'(active), 0);
      en       = 1'b1;
      model_on = 1'b1;
      #1;
      grant_once(FIXED ? 2'b01 : 2'b10, FIXED ? 8'h11 : 8'h22, 0, 0);
      en = 1'b0;
      chk("drop_en_active", 32'(active), 1);
      n_rdy = 0;
      n_to  = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (req_ready != '0) n_rdy++;
         if (timeout_err) n_to++;
      end
      chk("drop_en_ready", n_rdy, 0);
      chk("drop_en_timeout", n_to, 0);
      chk("drop_en_done", 32'(active), 0);
      req_valid = 2'b10;
      en        = 1'b1;
      #1;
      grant_once(2'b10, 8'h22, 0, 0);
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the SoC UART transmitter between `N_REQ` byte producers, such as the CPU-side TDR path, a hardware event logger and a debug tracer. It sits between the requesters and `uart_transmitter`:
- Accepts one byte at a time from the selected requester.
- Issues a single `tx_data_valid` pulse for that byte.
- Tracks `tx_busy` until the frame completes.
- Then grants the next requester.

Arbitration is round-robin by default. A start-timeout guard recovers the arbiter if the transmitter never starts, for example when the UART is disabled or the clock divider is unset.

## Interface
Parameters:
- `N_REQ`, default 2: number of requesters; legal range 2..8.
- `START_TIMEOUT`, default 4096: cycles to wait for `tx_busy` to rise after a pulse.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `en`, in, 1: arbitration enable; driven by UART CR.en.
- `req_valid`, in, `N_REQ`: per-requester byte pending.
- `req_data`, in, `N_REQ`x8: per-requester byte; must be stable while valid.
- `req_ready`, out, `N_REQ`: one-cycle capture acknowledge; one-hot or zero.
- `tx_data`, out, 8: byte to transmitter; holds the captured byte.
- `tx_data_valid`, out, 1: one-cycle start pulse to transmitter.
- `tx_busy`, in, 1: transmitter busy.
- `grant_id`, out, `$clog2(N_REQ)`: index of the last or current granted requester.
- `active`, out, 1: high in any state except IDLE.
- `timeout_err`, out, 1: one-cycle pulse when a start timeout occurs.

## Operation
Reset values: all outputs 0, state IDLE, round-robin pointer 0, timeout counter 0.

State machine:
- **IDLE**:
  - Condition: `en`=1, any `req_valid`=1, `tx_busy`=0.
  - Picker selects winner w.
  - `req_ready[w]`=1 for one cycle.
  - `tx_data` <= `req_data[w]`, `grant_id` <= w.
  - Go to ISSUE.
- **ISSUE**: `tx_data_valid`=1 for exactly one cycle; counter cleared; go to WAIT_START.
- **WAIT_START**:
  - `tx_busy`=1: go to WAIT_DONE.
  - Else counter increments.
  - Counter reaches `START_TIMEOUT`-1: `timeout_err` pulse, go to IDLE. The byte is dropped and is not re-requested.
- **WAIT_DONE**: `tx_busy`=0: go to IDLE.

Round-robin pointer:
- Updated on leaving WAIT_DONE or on timeout, to w+1 mod `N_REQ`.
- The search starts at the pointer and wraps at `N_REQ`-1 to 0.

Enable behaviour:
- `en`=0 blocks new grants only.
- An in-flight byte completes or times out normally.

Data integrity:
- A requester dropping `req_valid` before its grant loses nothing; no byte is captured.
- `req_data` is sampled only in the grant cycle.

Simultaneous events:
- All valid: the requester nearest the pointer wins.
- A requester re-asserting valid immediately after its ready does not win again while another requester is pending.
- `tx_busy` high in IDLE, e.g. after a transmit started elsewhere: grants are stalled until it falls.

Reset mid-operation: immediate return to IDLE, pointer 0, no pulse emitted. Any byte in the transmitter is the transmitter's concern.

## Timing
- Grant cycle N: `req_ready` high in N.
- `tx_data_valid` high in N+1.
- `tx_data` is valid from N+1 and holds until the next grant.
- Detection of `tx_busy` rise: one cycle after the rise.
- Earliest next grant: the cycle after `tx_busy` is sampled low in WAIT_DONE. That is two cycles after busy falls, counting the IDLE sampling cycle.
- Timeout: `timeout_err` is asserted `START_TIMEOUT` cycles after the ISSUE cycle; IDLE follows in the next cycle.
- Back-to-back throughput: one byte per frame plus 3 cycles.

## Configuration
- Macro: `UART_TX_ARBITER_FIXED_PRIORITY_EN`.
- Defined: fixed priority. Lowest index wins, the pointer is ignored, and requester 0 can starve the others.
- Undefined (default): round-robin as specified above.
- `grant_id`, the timeout and all timing are identical in both builds.

## Structure
- **Package `uart_tx_arbiter_pkg`**:
  - State enum `uart_tx_arb_state_t` with values IDLE, ISSUE, WAIT_START, WAIT_DONE.
  - Constant `UART_TX_ARB_MAX_REQ` = 8.
  - Default `START_TIMEOUT` constant.
- **Sub-module `uart_tx_arb_picker`**:
  - Combinational.
  - Inputs: `req_valid` vector and pointer.
  - Outputs: `winner` index and `any_valid`.
  - Contains the round-robin/fixed-priority macro switch.
- The top level holds the FSM, the data/id registers and the timeout counter.

## Test plan
- **Reset**: assert `rst_n`=0 with `req_valid`=2'b11 → all outputs 0. On release, req0 is granted first with `grant_id`=0 and `tx_data`=8'hA5.
- **Round-robin**: both requesters continuously valid, 0x11 from req0 and 0x22 from req1, with a `tx_busy` model that is high for 10 cycles → transmitter sees 11,22,11,22. Each `req_ready` is one cycle, each `tx_data_valid` follows it by exactly 1 cycle.
- **Start timeout**: `START_TIMEOUT`=16 and `tx_busy` tied 0 → `timeout_err` pulses 16 cycles after ISSUE. The arbiter then regrants the other requester, since the pointer advanced.
- **Enable gating**: `en`=0 with pending requests → no `req_ready` for 100 cycles. Drop `en` mid-frame → the current frame completes and no new grant follows.
- **Reset mid-frame**: `rst_n` pulse during WAIT_DONE → state IDLE, pointer 0, no spurious `tx_data_valid`.
- **Fixed priority**: with `UART_TX_ARBITER_FIXED_PRIORITY_EN` defined and both requesters continuously valid → only req0 is ever granted. When req0 drops, req1 is granted.
